// File: rtl/pip_mac_param.sv
// pip_mac_param: pipelined multiply-accumulate with configurable width, depth, signedness and ready/valid backpressure
module pip_mac_param #(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 3,
    parameter int SIGNED    = 0,
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 valid_in,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 ready_in,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 valid_out,
    output logic                 acc_ovf,
    input  logic                 ready_out
);
    if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc
        $error("pip_mac_param: ACC_WIDTH must be >= 2*WIDTH");
    end
    if (WIDTH < 2 || STAGES < 1) begin : g_bad_cfg
        $error("pip_mac_param: WIDTH must be >= 2 and STAGES >= 1");
    end
    logic [2*WIDTH-1:0] uprod;
    logic signed [2*WIDTH-1:0] sprod;
    logic [ACC_WIDTH-1:0] uext, sext, ext, acc, base, sum, fp;
    logic [ACC_WIDTH:0] wide;
    logic fv, fen, fclr, ov;
    assign ready_in = !(valid_out && !ready_out);
    assign uprod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign sprod = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
    assign uext = ACC_WIDTH'(uprod);
    assign sext = ACC_WIDTH'(sprod);
    assign ext = (SIGNED != 0) ? sext : uext;
    // With one stage the output register samples the inputs directly
    if (STAGES == 1) begin : g_direct
        assign fv   = valid_in;
        assign fp   = ext;
        assign fen  = acc_en;
        assign fclr = acc_clr;
    end else begin : g_pipe
        logic [STAGES-2:0] pv, pen, pclr;
        logic [ACC_WIDTH-1:0] pp [STAGES-1];
        always_ff @(posedge clk) begin
            if (rst) begin
                pv <= '0;
            end else if (ready_in) begin
                pv[0]   <= valid_in;
                pp[0]   <= ext;
                pen[0]  <= acc_en;
                pclr[0] <= acc_clr;
                for (int i = 1; i < STAGES-1; i++) begin
                    pv[i]   <= pv[i-1];
                    pp[i]   <= pp[i-1];
                    pen[i]  <= pen[i-1];
                    pclr[i] <= pclr[i-1];
                end
            end
        end
        assign fv   = pv[STAGES-2];
        assign fp   = pp[STAGES-2];
        assign fen  = pen[STAGES-2];
        assign fclr = pclr[STAGES-2];
    end
    assign base = fclr ? '0 : acc;
    assign wide = {1'b0, base} + {1'b0, fp};
    assign sum  = wide[ACC_WIDTH-1:0];
    // Signed overflow: both addends share a sign that the sum does not
    assign ov = (SIGNED != 0) ? (base[ACC_WIDTH-1] == fp[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1])
                              : wide[ACC_WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            result    <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else if (ready_in) begin
            valid_out <= fv;
            if (fv) begin
                result <= fen ? sum : fp;
                if (fen) begin
                    acc     <= sum;
                    acc_ovf <= !fclr && (acc_ovf || ov);
                end
            end
        end
    end
endmodule
